// File: rtl/sha256_core_pipe.sv
// SHA-256 compression core: one 512-bit block per pass, UNROLL rounds per clock.
// Latency: digest_valid pulses 64/UNROLL+1 cycles after the accepting edge.
// Backpressure: blk_ready is high only in IDLE; blk_valid is ignored while busy.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   blk_valid/ready   block handshake; blk_data holds W0 in [511:480] .. W15 in [31:0]
//   blk_first         block starts a new message (chain from IV / midstate)
//   digest_valid      one-cycle pulse when digest has been updated
//   digest            chaining state H, H0 in [255:224] .. H7 in [31:0]
//   busy              high while a block is in flight
//   mid_use, mid_in   only with SHA256_MIDSTATE_EN: initial state override on blk_first
//
// Optional feature macro: SHA256_MIDSTATE_EN

module sha256_core_pipe #(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
  output logic         digest_valid,
  output logic [255:0] digest,
  output logic         busy
`ifdef SHA256_MIDSTATE_EN
  ,
  input  logic         mid_use,
  input  logic [255:0] mid_in
`endif
);

  generate
    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
      $fatal(1, "sha256_core_pipe: UNROLL must be 1, 2 or 4");
    end
  endgenerate

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [5:0] T_LAST = 6'(64 - UNROLL);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Round primitives
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_s0(input logic [31:0] x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction

  function automatic logic [31:0] big_s1(input logic [31:0] x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction

  function automatic logic [31:0] sml_s0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sml_s1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  // One compression round on packed {a,b,c,d,e,f,g,h}.
  function automatic logic [255:0] sha_round(input logic [255:0] s,
                                             input logic [31:0]  k,
                                             input logic [31:0]  w);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + big_s1(e) + ((e & f) ^ (~e & g)) + k + w;
    t2 = big_s0(a) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  // Slide the 16-word window by one: the word at [511:480] is W[t]; the
  // newly computed W[t+16] enters at [31:0]. Words computed past W[63] are
  // never consumed.
  function automatic logic [511:0] sched_next(input logic [511:0] win);
    logic [31:0] w_new;
    w_new = sml_s1(win[63:32]) + win[223:192] + sml_s0(win[479:448]) + win[511:480];
    return {win[479:0], w_new};
  endfunction

  function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[i*32 +: 32] = x[i*32 +: 32] + y[i*32 +: 32];
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e       state_q, state_d;
  logic [5:0]   t_q, t_d;
  logic [255:0] work_q, work_d;
  logic [511:0] win_q, win_d;
  logic [255:0] base_q, base_d;   // chaining value added back in FINAL
  logic [255:0] h_q, h_d;
  logic         blk_ready_q, blk_ready_d;
  logic         busy_q, busy_d;
  logic         digest_valid_q, digest_valid_d;

  logic [255:0] init_val;
  logic [255:0] rnd_work;
  logic [511:0] rnd_win;

  // Starting chaining value for the block being offered.
  always_comb begin
    init_val = h_q;
    if (blk_first) begin
      init_val = IV;
`ifdef SHA256_MIDSTATE_EN
      if (mid_use) begin
        init_val = mid_in;
      end
`endif
    end
  end

  // UNROLL rounds chained combinationally from the registered working state.
  always_comb begin
    rnd_work = work_q;
    rnd_win  = win_q;
    for (int i = 0; i < UNROLL; i++) begin
      rnd_work = sha_round(rnd_work, K[t_q + 6'(i)], rnd_win[511:480]);
      rnd_win  = sched_next(rnd_win);
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    work_d  = work_q;
    win_d   = win_q;
    base_d  = base_q;
    h_d     = h_q;

    case (state_q)
      ST_IDLE: begin
        if (blk_valid && blk_ready_q) begin
          work_d  = init_val;
          base_d  = init_val;
          win_d   = blk_data;
          t_d     = 6'd0;
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        work_d = rnd_work;
        win_d  = rnd_win;
        t_d    = t_q + 6'(UNROLL);   // wraps back to 0 after the last round
        if (t_q == T_LAST) begin
          state_d = ST_FINAL;
        end
      end
      ST_FINAL: begin
        h_d     = add8(base_q, work_q);
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        t_d     = 6'd0;
      end
    endcase

    blk_ready_d    = (state_d == ST_IDLE);
    busy_d         = (state_d != ST_IDLE);
    digest_valid_d = (state_q == ST_FINAL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      t_q            <= 6'd0;
      work_q         <= '0;
      win_q          <= '0;
      base_q         <= '0;
      h_q            <= '0;
      blk_ready_q    <= 1'b1;
      busy_q         <= 1'b0;
      digest_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      t_q            <= t_d;
      work_q         <= work_d;
      win_q          <= win_d;
      base_q         <= base_d;
      h_q            <= h_d;
      blk_ready_q    <= blk_ready_d;
      busy_q         <= busy_d;
      digest_valid_q <= digest_valid_d;
    end
  end

  assign blk_ready    = blk_ready_q;
  assign busy         = busy_q;
  assign digest_valid = digest_valid_q;
  assign digest       = h_q;

endmodule

// File: tb/tb_sha256_core_pipe.sv
// Directed bench for sha256_core_pipe: one UNROLL=1 and one UNROLL=4 instance.
// Known-answer digests, exact digest_valid latency, back-to-back blocks,
// mid-block reset, input noise while busy, optional midstate path.

module tb_sha256_core_pipe;

  localparam logic [511:0] ABC_BLK   = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, {15{32'h0}}};
  localparam logic [511:0] M1_BLK = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] M2_BLK = {{15{32'h0}}, 32'h000001c0};

  localparam logic [255:0] ABC_DIG   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] MSG_DIG   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         vld1, vld4;
  logic [511:0] data;
  logic         first;

  logic         rdy1, rdy4, dv1, dv4, busy1, busy4;
  logic [255:0] dig1, dig4;

`ifdef SHA256_MIDSTATE_EN
  logic         mid_use;
  logic [255:0] mid_in;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sha256_core_pipe #(.UNROLL(1)) u1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .blk_valid    (vld1),
    .blk_ready    (rdy1),
    .blk_data     (data),
    .blk_first    (first),
    .digest_valid (dv1),
    .digest       (dig1),
    .busy         (busy1)
`ifdef SHA256_MIDSTATE_EN
    ,
    .mid_use      (mid_use),
    .mid_in       (mid_in)
`endif
  );

  sha256_core_pipe #(.UNROLL(4)) u4 (
    .clk          (clk),
    .rst_n        (rst_n),
    .blk_valid    (vld4),
    .blk_ready    (rdy4),
    .blk_data     (data),
    .blk_first    (first),
    .digest_valid (dv4),
    .digest       (dig4),
    .busy         (busy4)
`ifdef SHA256_MIDSTATE_EN
    ,
    .mid_use      (mid_use),
    .mid_in       (mid_in)
`endif
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_vld(input int s, input logic v);
    if (s == 0) vld1 = v;
    else        vld4 = v;
  endtask

  // Called at a negedge with the selected core idle. Offers one block, then
  // counts clock edges from the accepting edge until digest_valid is seen.
  // Returns at the negedge where digest_valid is high, so a following call
  // offers its block in the very cycle blk_ready returns.
  task automatic run_block(input int s, input logic [511:0] d, input logic f,
                           input bit noise, input int lat, input bit do_dig,
                           input logic [255:0] exp_dig, input string tag);
    int n;
    bit seen;
    logic rdy, bsy, dv;
    logic [255:0] dg;
    rdy = (s == 0) ? rdy1 : rdy4;
    chk({tag, "_rdy_at_offer"}, {255'd0, rdy}, 256'd1);
    data  = d;
    first = f;
    set_vld(s, 1'b1);
    @(posedge clk);
    n    = 0;
    seen = 0;
    while (n <= 200) begin
      @(negedge clk);
      bsy = (s == 0) ? busy1 : busy4;
      rdy = (s == 0) ? rdy1 : rdy4;
      dv  = (s == 0) ? dv1 : dv4;
      if (n == 0) begin
        chk({tag, "_busy"}, {255'd0, bsy}, 256'd1);
        chk({tag, "_rdy_busy"}, {255'd0, rdy}, 256'd0);
      end
      if (dv) begin
        seen = 1;
        break;
      end
      if (noise) begin
        set_vld(s, 1'b1);
        for (int i = 0; i < 16; i++) data[i*32 +: 32] = $urandom;
        first = 1'($urandom_range(0, 1));
      end else begin
        set_vld(s, 1'b0);
      end
      n++;
    end
    set_vld(s, 1'b0);
    chk({tag, "_latency"}, seen ? 256'(n) : 256'd9999, 256'(lat));
    if (do_dig) begin
      dg = (s == 0) ? dig1 : dig4;
      chk({tag, "_digest"}, dg, exp_dig);
    end
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0;
    vld1  = 1'b0;
    vld4  = 1'b0;
    data  = '0;
    first = 1'b0;
`ifdef SHA256_MIDSTATE_EN
    mid_use = 1'b0;
    mid_in  = '0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_dv1", {255'd0, dv1}, 256'd0);
    chk("rst_busy1", {255'd0, busy1}, 256'd0);
    chk("rst_dig1", dig1, 256'd0);
    chk("rst_dig4", dig4, 256'd0);
    rst_n = 1'b1;
    chk("rst_rdy1", {255'd0, rdy1}, 256'd1);
    chk("rst_rdy4", {255'd0, rdy4}, 256'd1);

    // Single block "abc" immediately after reset release.
    run_block(0, ABC_BLK, 1'b1, 0, 65, 1, ABC_DIG, "abc_u1");
    repeat (3) @(negedge clk);
    chk("abc_u1_hold", dig1, ABC_DIG);
    chk("abc_u1_dv_low", {255'd0, dv1}, 256'd0);

    // Empty message on the 4-round core.
    run_block(1, EMPTY_BLK, 1'b1, 0, 17, 1, EMPTY_DIG, "empty_u4");

    // Two-block message, second block offered in the ready-return cycle.
    run_block(0, M1_BLK, 1'b1, 0, 65, 0, '0, "msg_u1_b1");
    run_block(0, M2_BLK, 1'b0, 0, 65, 1, MSG_DIG, "msg_u1_b2");
    run_block(1, M1_BLK, 1'b1, 0, 17, 0, '0, "msg_u4_b1");
    run_block(1, M2_BLK, 1'b0, 0, 17, 1, MSG_DIG, "msg_u4_b2");

    // Reset while round 30 is in flight: block is dropped, state cleared.
    @(negedge clk);
    data  = ABC_BLK;
    first = 1'b1;
    vld1  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vld1 = 1'b0;
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (dv1) pulses++;
    end
    chk("midrst_no_pulse", 256'(pulses), 256'd0);
    chk("midrst_dig", dig1, 256'd0);
    chk("midrst_rdy", {255'd0, rdy1}, 256'd1);
    chk("midrst_busy", {255'd0, busy1}, 256'd0);
    run_block(0, ABC_BLK, 1'b1, 0, 65, 1, ABC_DIG, "abc_after_rst");

    // blk_valid held high with random data while the core is busy.
    run_block(0, ABC_BLK, 1'b1, 1, 65, 1, ABC_DIG, "abc_noise");

`ifdef SHA256_MIDSTATE_EN
    // Midstate: hash block 1, reinject its state, finish with block 2 as first.
    run_block(1, M1_BLK, 1'b1, 0, 17, 0, '0, "mid_b1");
    mid_in  = dig4;
    mid_use = 1'b1;
    run_block(1, M2_BLK, 1'b1, 0, 17, 1, MSG_DIG, "mid_b2");
    mid_use = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sha256_core_pipe.md
SHA256_CORE_PIPE -- requirements
Module: sha256_core_pipe

Interface
REQ-001 SHALL have parameter UNROLL, default 1; rounds per clock, legal values 1, 2, 4.
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port blk_valid, input, 1, a 512-bit message block is offered.
REQ-005 SHALL have port blk_ready, output, 1, core can accept a block.
REQ-006 SHALL have port blk_data, input, 512; the offered block, with W0 = blk_data[511:480] and W15 = blk_data[31:0], big-endian.
REQ-007 SHALL have port blk_first, input, 1; when set, the block starts a new message, and the chaining state loads IV (or midstate, REQ-026).
REQ-008 SHALL have port digest_valid, output, 1, a one-cycle pulse when the digest is updated.
REQ-009 SHALL have port digest, output, 256; H0 = digest[255:224] and H7 = digest[31:0].
REQ-010 SHALL have port busy, output, 1, high while a block is being compressed.

Function
REQ-011 SHALL implement an FSM with three states.
- IDLE: blk_ready=1, busy=0.
- ROUND: blk_ready=0, busy=1.
- FINAL: blk_ready=0, busy=1.
REQ-012 SHALL accept a block on the rising edge where blk_valid && blk_ready, and latch blk_data into a 16-word schedule window.
- On blk_first, SHALL load working registers a..h from IV; otherwise SHALL load them from the current chaining H.
- SHALL go IDLE->ROUND.
REQ-013 SHALL ignore blk_valid outside IDLE, with no side effects.
REQ-014 SHALL perform, in ROUND, UNROLL consecutive FIPS 180-4 rounds per cycle, using K[t] from an internal 64-entry constant table.
- SHALL compute W[t] for t>=16 on the fly from the sliding window: s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16].
REQ-015 SHALL hold the round counter t at 0..63.
- t SHALL advance by UNROLL per cycle.
- After the cycle processing round 63, the FSM SHALL go ROUND->FINAL.
REQ-016 SHALL, in FINAL, set H[i] = H[i] + working[i] mod 2^32 (H[i] taken from IV when blk_first was latched), then go FINAL->IDLE.
- SHALL assert digest_valid for exactly the following cycle.
REQ-017 SHALL deliver digest_valid high exactly 64/UNROLL+1 cycles after the accepting edge.
- blk_ready SHALL be high in that same cycle, so back-to-back blocks are possible.
REQ-018 SHALL make all additions modulo 2^32; carries out of bit 31 SHALL be discarded.
REQ-019 SHALL hold digest stable, equal to H, between pulses.
- The digest of the final block of a multi-block message SHALL be the message hash.
REQ-020 SHALL treat padding as the caller's responsibility; the core SHALL compress blocks exactly as given.
REQ-021 SHALL reject an illegal UNROLL (not 1, 2 or 4) at elaboration with a fatal error.

Reset
REQ-022 SHALL, on rst_n low, asynchronously force the following:
- state=IDLE, t=0;
- blk_ready=1 once rst_n is high, busy=0, digest_valid=0;
- H and digest = 0.
REQ-023 SHALL, on reset during ROUND or FINAL, abandon the in-flight block with no digest_valid pulse.
REQ-024 SHALL make the first block accepted after reset with blk_first=0 chain from H=0; callers SHALL set blk_first on the first block.
REQ-025 SHALL release reset synchronously, with the first acceptance possible on the first rising edge with rst_n high.

Configuration
REQ-026 SHALL, with macro SHA256_MIDSTATE_EN defined, add ports mid_use (input, 1) and mid_in (input, 256).
- A blk_first block accepted with mid_use=1 SHALL initialise from mid_in instead of IV.
- This is used to skip the constant first block of an 80-byte header.
REQ-027 SHALL, without SHA256_MIDSTATE_EN, have neither port exist and always use IV on blk_first.

Verification
REQ-028 SHALL cover: "abc" single padded block, blk_first=1, UNROLL=1 -> digest_valid 65 cycles later, digest = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
REQ-029 SHALL cover: empty-message block (0x80 then zeros, length 0), UNROLL=4 -> digest_valid 17 cycles later, digest = e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
REQ-030 SHALL cover: two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", second block offered on the cycle ready returns, blk_first=0 on the second -> digests accepted back-to-back, final digest = 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
REQ-031 SHALL cover: rst_n pulsed low at t=30 of a block -> no digest_valid, digest=0, blk_ready=1; a re-sent "abc" then yields REQ-028's value.
REQ-032 SHALL cover: blk_valid held high with random data during ROUND -> result unchanged versus REQ-028.
REQ-033 SHALL cover, with SHA256_MIDSTATE_EN: block 1 of "abcdbcde..." hashed, its digest fed to mid_in with mid_use=1 and block 2 sent with blk_first=1 -> digest equals REQ-030's value.
